// File: rtl/battle_pkg.sv
// Shared phase codes and internal state encoding for the battle screen.
// The phase codes are also decoded by the player- and enemy-attack stages.
package battle_pkg;

   localparam logic [3:0] PH_TITLE      = 4'b0000;
   localparam logic [3:0] PH_PLAYER     = 4'b0001;
   localparam logic [3:0] PH_ENEMY      = 4'b0010;
   localparam logic [3:0] PH_WIN        = 4'b0011;
   localparam logic [3:0] PH_LOSE       = 4'b0100;
   localparam logic [3:0] PH_TRANSITION = 4'b0101;

   typedef enum logic [2:0] {
      S_TITLE,
      S_PLAYER,
      S_GAP_PE,
      S_ENEMY,
      S_GAP_EP,
      S_WIN,
      S_LOSE
   } state_t;

   // Fibonacci step, taps 8,6,5,4; feedback enters at bit 0.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [3:0] phase_code(input state_t s);
      case (s)
         S_TITLE:            return PH_TITLE;
         S_PLAYER:           return PH_PLAYER;
         S_GAP_PE, S_GAP_EP: return PH_TRANSITION;
         S_ENEMY:            return PH_ENEMY;
         S_WIN:              return PH_WIN;
         S_LOSE:             return PH_LOSE;
         default:            return PH_TITLE;
      endcase
   endfunction

endpackage

// File: rtl/battle_sequencer_lfsr8.sv
// 8-bit pattern LFSR; advances one step per step_in pulse.
module lfsr8 import battle_pkg::*; #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_in,
   output logic [7:0] value_out
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else if (step_in) begin
         lfsr_q <= lfsr8_next(lfsr_q);
      end
   end

   assign value_out = lfsr_q;

endmodule

// File: rtl/battle_sequencer.sv
// Battle-screen turn controller: sequences player/enemy phases with a fixed
// transition gap, tracks completed turns and picks the enemy attack pattern.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_TITLE  | title screen, waiting for start
//   S_PLAYER | player attack stage running
//   S_GAP_PE | transition gap, player -> enemy (or win)
//   S_ENEMY  | enemy attack (dodge) stage running
//   S_GAP_EP | transition gap, enemy -> player (or lose)
//   S_WIN    | win screen, start honoured after hold expires
//   S_LOSE   | lose screen, start honoured after hold expires
module battle_sequencer import battle_pkg::*; #(
   parameter int unsigned GAP_CYCLES      = 6_500_000,
   parameter int unsigned END_HOLD_CYCLES = 130_000_000,
   parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_in,
   input  logic        player_finished_in,
   input  logic        enemy_finished_in,
   input  logic [10:0] enemy_hp_in,
   input  logic [7:0]  player_hp_in,
   output logic [3:0]  state_out,
   output logic        phase_start_out,
   output logic [7:0]  turn_out,
   output logic [1:0]  attack_sel_out
);

   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] HOLD_LAST = 32'(END_HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   logic [3:0]  state_out_q;
   logic        phase_start_q;
   logic [7:0]  turn_q;
   logic [1:0]  sel_q;
   logic [7:0]  lfsr_val;
   logic [1:0]  sel_post;
   logic        enemy_entry;
   logic        cnt_run;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_TITLE:  if (start_in) state_d = S_PLAYER;
         S_PLAYER: if (player_finished_in) state_d = S_GAP_PE;
         S_GAP_PE: if (cnt_q == GAP_LAST) state_d = (enemy_hp_in == '0) ? S_WIN : S_ENEMY;
         S_ENEMY: begin
            if (player_hp_in == '0)     state_d = S_LOSE;
            else if (enemy_finished_in) state_d = S_GAP_EP;
         end
         S_GAP_EP: if (cnt_q == GAP_LAST) state_d = (player_hp_in == '0) ? S_LOSE : S_PLAYER;
         S_WIN, S_LOSE: if (start_in && cnt_q == HOLD_LAST) state_d = S_TITLE;
         default:  state_d = S_TITLE;
      endcase
   end

   assign enemy_entry = (state_d == S_ENEMY) && (state_q != S_ENEMY);

   // Hold counter freezes at its last value so start stays honoured indefinitely.
   assign cnt_run = (state_q == S_GAP_PE) || (state_q == S_GAP_EP) ||
                    (((state_q == S_WIN) || (state_q == S_LOSE)) && (cnt_q != HOLD_LAST));

   // The pattern register must see the post-step value on the same edge the LFSR steps.
   assign sel_post = 2'(lfsr8_next(lfsr_val));

   lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .step_in   (enemy_entry),
      .value_out (lfsr_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_TITLE;
         cnt_q         <= '0;
         state_out_q   <= PH_TITLE;
         phase_start_q <= 1'b0;
         turn_q        <= '0;
         sel_q         <= '0;
      end else begin
         state_q       <= state_d;
         state_out_q   <= phase_code(state_d);
         phase_start_q <= (state_d != state_q);

         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (cnt_run) begin
            cnt_q <= cnt_q + 32'd1;
         end

         if (state_q == S_TITLE && state_d == S_PLAYER) begin
            turn_q <= '0;
         end else if (state_q == S_PLAYER && state_d == S_GAP_PE && turn_q != 8'hFF) begin
            turn_q <= turn_q + 8'd1;
         end

         if (enemy_entry) begin
            sel_q <= sel_post;
         end
      end
   end

   assign state_out       = state_out_q;
   assign phase_start_out = phase_start_q;
   assign turn_out        = turn_q;
   assign attack_sel_out  = sel_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer: directed vector table, hand-built
// corner sequences, a 300-turn saturation run and randomized traffic.
module tb_battle_sequencer;

   localparam int GAP  = 4;
   localparam int HOLD = 8;
   localparam logic [7:0] SEED = 8'hA5;

   localparam int C_TITLE = 0, C_PLAYER = 1, C_ENEMY = 2, C_WIN = 3, C_LOSE = 4, C_TRANS = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_in = 1'b0;
   logic        pf = 1'b0;
   logic        ef = 1'b0;
   logic [10:0] ehp = 11'd50;
   logic [7:0]  php = 8'd100;
   logic [3:0]  state_out;
   logic        phase_start_out;
   logic [7:0]  turn_out;
   logic [1:0]  attack_sel_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   battle_sequencer #(
      .GAP_CYCLES(GAP), .END_HOLD_CYCLES(HOLD), .LFSR_SEED(SEED)
   ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .start_in           (start_in),
      .player_finished_in (pf),
      .enemy_finished_in  (ef),
      .enemy_hp_in        (ehp),
      .player_hp_in       (php),
      .state_out          (state_out),
      .phase_start_out    (phase_start_out),
      .turn_out           (turn_out),
      .attack_sel_out     (attack_sel_out)
   );

   // Reference model: phase code, cycles spent in the phase, where a gap leads.
   int         m_code = C_TITLE;
   bit         m_to_enemy = 1'b0;
   int         m_age = 0;
   int         m_turn = 0;
   logic [7:0] m_lfsr = SEED;
   logic [1:0] m_sel = 2'b00;
   bit         m_ps = 1'b0;

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
      int   taps[4] = '{8, 6, 5, 4};
      logic b = 1'b0;
      foreach (taps[k]) b ^= v[taps[k]-1];
      return {v[6:0], b};
   endfunction

   task automatic model_step(input logic r, s, f_p, f_e, input logic [10:0] hp_e, input logic [7:0] hp_p);
      int nxt;
      bit nte;
      if (r) begin
         m_code = C_TITLE; m_to_enemy = 1'b0; m_age = 0; m_turn = 0;
         m_lfsr = SEED; m_sel = 2'b00; m_ps = 1'b0;
         return;
      end
      nxt = m_code;
      nte = m_to_enemy;
      case (m_code)
         C_TITLE: if (s) begin nxt = C_PLAYER; m_turn = 0; end
         C_PLAYER: if (f_p) begin
            nxt = C_TRANS; nte = 1'b1;
            if (m_turn < 255) m_turn++;
         end
         C_TRANS: if (m_age == GAP - 1) begin
            if (m_to_enemy) begin
               if (hp_e == 0) nxt = C_WIN;
               else begin
                  nxt = C_ENEMY;
                  m_lfsr = lfsr_adv(m_lfsr);
                  m_sel = m_lfsr[1:0];
               end
            end else begin
               nxt = (hp_p == 0) ? C_LOSE : C_PLAYER;
            end
         end
         C_ENEMY: begin
            if (hp_p == 0) nxt = C_LOSE;
            else if (f_e) begin nxt = C_TRANS; nte = 1'b0; end
         end
         C_WIN, C_LOSE: if (s && m_age >= HOLD - 1) nxt = C_TITLE;
         default: nxt = C_TITLE;
      endcase
      m_ps = (nxt != m_code);
      m_age = m_ps ? 0 : m_age + 1;
      m_code = nxt;
      m_to_enemy = nte;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, s, f_p, f_e, input logic [10:0] hp_e, input logic [7:0] hp_p);
      rst = r; start_in = s; pf = f_p; ef = f_e; ehp = hp_e; php = hp_p;
      @(posedge clk);
      model_step(r, s, f_p, f_e, hp_e, hp_p);
      #1;
      chk("state", int'(state_out), m_code);
      chk("phase_start", int'(phase_start_out), int'(m_ps));
      chk("turn", int'(turn_out), m_turn);
      chk("attack_sel", int'(attack_sel_out), int'(m_sel));
   endtask

   typedef struct {
      logic r, s, f_p, f_e;
      logic [10:0] hp_e;
      logic [7:0]  hp_p;
      logic [3:0]  st;
      logic        ps;
      logic [7:0]  turn;
      logic [1:0]  sel;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic r, s, f_p, f_e, input int hp_e, hp_p,
                                input int st, ps, turn, sel);
      vec_t v;
      v.r = r; v.s = s; v.f_p = f_p; v.f_e = f_e;
      v.hp_e = 11'(hp_e); v.hp_p = 8'(hp_p);
      v.st = 4'(st); v.ps = ps[0]; v.turn = 8'(turn); v.sel = 2'(sel);
      return v;
   endfunction

   logic [7:0] lfsr_vals[$];
   bit         lfsr_seen[256];

   initial begin
      // r s pf ef ehp php | state ps turn sel
      vecs.push_back(mkv(1,0,0,0, 50,100, 0,0,0,0));
      vecs.push_back(mkv(0,0,0,0, 50,100, 0,0,0,0));
      vecs.push_back(mkv(0,1,0,0, 50,100, 1,1,0,0));
      vecs.push_back(mkv(0,0,1,0, 50,100, 5,1,1,0));
      vecs.push_back(mkv(0,0,1,0, 50,100, 5,0,1,0));
      vecs.push_back(mkv(0,0,1,0, 50,100, 5,0,1,0));
      vecs.push_back(mkv(0,0,1,0, 50,100, 5,0,1,0));
      vecs.push_back(mkv(0,0,1,0, 50,100, 2,1,1,2));
      vecs.push_back(mkv(0,1,0,0, 50,100, 2,0,1,2));
      vecs.push_back(mkv(0,0,0,1, 50,100, 5,1,1,2));
      vecs.push_back(mkv(0,0,0,1, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,1, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,1, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,1, 50,100, 1,1,1,2));
      vecs.push_back(mkv(0,0,1,0,  0,100, 5,1,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 5,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 5,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 5,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,1,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,1,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,1,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,0,0,0,  0,100, 3,0,2,2));
      vecs.push_back(mkv(0,1,0,0,  0,100, 0,1,2,2));
      vecs.push_back(mkv(0,0,0,0, 50,100, 0,0,2,2));
      vecs.push_back(mkv(0,1,0,0, 50,100, 1,1,0,2));
      vecs.push_back(mkv(0,0,1,0, 50,100, 5,1,1,2));
      vecs.push_back(mkv(0,0,0,0, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,0, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,0, 50,100, 5,0,1,2));
      vecs.push_back(mkv(0,0,0,0, 50,100, 2,1,1,1));
      vecs.push_back(mkv(0,0,0,1, 50,  0, 4,1,1,1));
      vecs.push_back(mkv(0,1,0,0, 50,  0, 4,0,1,1));

      foreach (vecs[i]) begin
         cyc(vecs[i].r, vecs[i].s, vecs[i].f_p, vecs[i].f_e, vecs[i].hp_e, vecs[i].hp_p);
         chk($sformatf("vec%0d_state", i), int'(state_out), int'(vecs[i].st));
         chk($sformatf("vec%0d_ps", i), int'(phase_start_out), int'(vecs[i].ps));
         chk($sformatf("vec%0d_turn", i), int'(turn_out), int'(vecs[i].turn));
         chk($sformatf("vec%0d_sel", i), int'(attack_sel_out), int'(vecs[i].sel));
      end

      // Reset while in ENEMY: everything returns to reset values, no pulse.
      cyc(1,0,0,0, 50,100);
      cyc(0,1,0,0, 50,100);
      for (int i = 0; i < 5; i++) cyc(0,0,1,0, 50,100);
      chk("in_enemy", int'(state_out), C_ENEMY);
      cyc(0,0,0,0, 50,100);
      cyc(1,0,0,0, 50,100);
      chk("rst_state", int'(state_out), 0);
      chk("rst_ps", int'(phase_start_out), 0);
      chk("rst_turn", int'(turn_out), 0);
      chk("rst_sel", int'(attack_sel_out), 0);

      // Reset mid-gap, then confirm a full-length gap and the LFSR restarting from seed.
      cyc(0,1,0,0, 50,100);
      cyc(0,0,1,0, 50,100);
      cyc(0,0,1,0, 50,100);
      cyc(1,0,0,0, 50,100);
      chk("rst_gap_state", int'(state_out), 0);
      cyc(0,1,0,0, 50,100);
      for (int i = 0; i < 4; i++) begin
         cyc(0,0,1,0, 50,100);
         chk("gap_len", int'(state_out), C_TRANS);
      end
      cyc(0,0,0,0, 50,100);
      chk("sel_after_rst", int'(attack_sel_out), 2);

      // Gap towards the player phase diverts to LOSE when player HP hits 0 at exit.
      cyc(0,0,0,1, 50,100);
      for (int i = 0; i < 3; i++) cyc(0,0,0,0, 50,100);
      cyc(0,0,0,0, 50,0);
      chk("gap_ep_lose", int'(state_out), C_LOSE);

      // 300 full turns: turn counter saturates; LFSR sampled on each enemy entry.
      cyc(1,0,0,0, 50,100);
      cyc(0,1,0,0, 50,100);
      for (int i = 0; i < 3010; i++) begin
         cyc(0,0,1,1, 50,100);
         if (state_out == 4'b0010 && phase_start_out) lfsr_vals.push_back(u_dut.u_lfsr.value_out);
      end
      chk("turn_sat", int'(turn_out), 255);
      chk("lfsr_entries_ge_256", int'(lfsr_vals.size() >= 256), 1);
      if (lfsr_vals.size() >= 256) begin
         for (int i = 0; i < 255; i++) begin
            chk("lfsr_nonzero", int'(lfsr_vals[i] != 8'h00), 1);
            chk("lfsr_unique", int'(lfsr_seen[lfsr_vals[i]]), 0);
            lfsr_seen[lfsr_vals[i]] = 1'b1;
         end
         chk("lfsr_period", int'(lfsr_vals[255]), int'(lfsr_vals[0]));
      end

      // Randomized traffic against the model.
      cyc(1,0,0,0, 50,100);
      for (int i = 0; i < 4000; i++) begin
         logic        r_r, r_s, r_pf, r_ef;
         logic [10:0] r_ehp;
         logic [7:0]  r_php;
         r_r   = ($urandom_range(299) == 0);
         r_s   = ($urandom_range(7) == 0);
         r_pf  = ($urandom_range(3) == 0);
         r_ef  = ($urandom_range(3) == 0);
         r_ehp = ($urandom_range(3) == 0) ? 11'd0 : 11'($urandom_range(2047, 1));
         r_php = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
         cyc(r_r, r_s, r_pf, r_ef, r_ehp, r_php);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
